// File: rtl/sobel_gradient.sv
// 3x3 Sobel gradient stage: two internal line buffers, a shifting window and a
// three-edge pipeline producing |Gx|+|Gy| and a quantised direction per interior pixel.
module sobel_gradient #(
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   output logic [10:0] out_mag,
   output logic [1:0]  out_dir,
   output logic        out_sof,
   output logic        out_eof
);

   localparam int unsigned CW = $clog2(IMG_WIDTH);
   localparam int unsigned RW = $clog2(IMG_HEIGHT);
   localparam int unsigned SW = 10;   // weighted column/row sum
   localparam int unsigned GW = 11;   // signed gradient
   localparam int unsigned PW = 20;   // direction compare products

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          last_col;
   logic          last_row;
   logic          qualify;

   logic [7:0] lb_a [IMG_WIDTH];   // row r-1
   logic [7:0] lb_b [IMG_WIDTH];   // row r-2
   logic [7:0] top_new;
   logic [7:0] mid_new;
   logic [7:0] w_top [3];
   logic [7:0] w_mid [3];
   logic [7:0] w_bot [3];

   logic          v1, sof1, eof1;
   logic          v2, sof2, eof2;
   logic [SW-1:0] left_sum, right_sum, top_sum, bot_sum;
   logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
   logic [SW-1:0] ax, ay;
   logic [GW-1:0] mag_c;
   logic [PW-1:0] ay_k, ax_lo, ax_hi;
   logic [1:0]    dir_c;

   // in_sof overrides the counters for the current beat
   assign cur_col  = in_sof ? '0 : col;
   assign cur_row  = in_sof ? '0 : row;
   assign last_col = (cur_col == CW'(IMG_WIDTH - 1));
   assign last_row = (cur_row == RW'(IMG_HEIGHT - 1));
   assign qualify  = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : cur_row + RW'(1);
         end else begin
            col <= cur_col + CW'(1);
            row <= cur_row;
         end
      end
   end

   assign top_new = lb_b[cur_col];
   assign mid_new = lb_a[cur_col];

   // Line buffers and window carry no reset; stale data is masked by the row gate.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb_a[cur_col] <= in_data;
         lb_b[cur_col] <= mid_new;
         for (int j = 0; j < 2; j++) begin
            w_top[j] <= w_top[j+1];
            w_mid[j] <= w_mid[j+1];
            w_bot[j] <= w_bot[j+1];
         end
         w_top[2] <= top_new;
         w_mid[2] <= mid_new;
         w_bot[2] <= in_data;
      end
   end

   always_comb begin
      left_sum  = SW'(w_top[0]) + {1'b0, w_mid[0], 1'b0} + SW'(w_bot[0]);
      right_sum = SW'(w_top[2]) + {1'b0, w_mid[2], 1'b0} + SW'(w_bot[2]);
      top_sum   = SW'(w_top[0]) + {1'b0, w_top[1], 1'b0} + SW'(w_top[2]);
      bot_sum   = SW'(w_bot[0]) + {1'b0, w_bot[1], 1'b0} + SW'(w_bot[2]);
      gx_c      = GW'(right_sum) - GW'(left_sum);
      gy_c      = GW'(bot_sum) - GW'(top_sum);
   end

   always_comb begin
      ax    = gx_q[GW-1] ? SW'(-gx_q) : SW'(gx_q);
      ay    = gy_q[GW-1] ? SW'(-gy_q) : SW'(gy_q);
      mag_c = GW'(ax) + GW'(ay);
      ay_k  = PW'(ay) << 8;
      ax_lo = PW'(ax) * PW'(106);
      ax_hi = PW'(ax) * PW'(618);
      dir_c = 2'd0;
      if (ay_k <= ax_lo)
         dir_c = 2'd0;
      else if (ay_k >= ax_hi)
         dir_c = 2'd2;
      else if (gx_q[GW-1] == gy_q[GW-1])
         dir_c = 2'd1;
      else
         dir_c = 2'd3;
   end

   // Window valid -> gradient regs -> output regs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1        <= 1'b0;
         sof1      <= 1'b0;
         eof1      <= 1'b0;
         v2        <= 1'b0;
         sof2      <= 1'b0;
         eof2      <= 1'b0;
         gx_q      <= '0;
         gy_q      <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         out_mag   <= '0;
         out_dir   <= '0;
      end else begin
         v1        <= qualify;
         sof1      <= qualify && (cur_row == RW'(2)) && (cur_col == CW'(2));
         eof1      <= qualify && last_row && last_col;
         v2        <= v1;
         sof2      <= v1 && sof1;
         eof2      <= v1 && eof1;
         if (v1) begin
            gx_q <= gx_c;
            gy_q <= gy_c;
         end
         out_valid <= v2;
         out_sof   <= v2 && sof2;
         out_eof   <= v2 && eof2;
         if (v2) begin
            out_mag <= mag_c;
            out_dir <= dir_c;
         end
      end
   end

endmodule

// File: tb/tb_sobel_gradient.sv
// Scoreboard bench for sobel_gradient: an image-array model predicts each output
// and its arrival cycle; a negedge monitor pops and compares.
module tb_sobel_gradient;
   localparam int W = 8;
   localparam int H = 6;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [7:0]  in_data = 8'd0;
   logic        out_valid;
   logic [10:0] out_mag;
   logic [1:0]  out_dir;
   logic        out_sof;
   logic        out_eof;

   sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(out_valid), .out_mag(out_mag), .out_dir(out_dir),
      .out_sof(out_sof), .out_eof(out_eof)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mag;
      int dir;
      int sof;
      int eof;
      int cyc;
   } exp_t;

   exp_t sbq[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int mr = 0;
   int mc = 0;
   int gap_pct = 0;
   int img[H][W];
   int n_out = 0;
   int mag_sum = 0;
   int dir_sum = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: Sobel on the stored image around centre (r-1, c-1)
   function automatic exp_t model(input int r, input int c);
      exp_t e;
      int wgt[3];
      int gx, gy, ax, ay;
      wgt = '{1, 2, 1};
      gx = 0;
      gy = 0;
      for (int i = 0; i < 3; i++) begin
         gx += wgt[i] * (img[r-2+i][c] - img[r-2+i][c-2]);
         gy += wgt[i] * (img[r][c-2+i] - img[r-2][c-2+i]);
      end
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      e.mag = ax + ay;
      if (ay * 256 <= ax * 106)      e.dir = 0;
      else if (ay * 256 >= ax * 618) e.dir = 2;
      else if ((gx >= 0) == (gy >= 0)) e.dir = 1;
      else                           e.dir = 3;
      e.sof = (r == 2 && c == 2) ? 1 : 0;
      e.eof = (r == H-1 && c == W-1) ? 1 : 0;
      e.cyc = 0;
      return e;
   endfunction

   function automatic int pix(input int kind, input int r, input int c);
      case (kind)
         0: return 50;
         1: return (c >= 4) ? 100 : 0;
         2: return (r >= 3) ? 200 : 0;
         3: return 10 * (r + c);
         4: return 10 * (r + 7 - c);
         default: return int'($urandom_range(255));
      endcase
   endfunction

   // Issue one accepted beat (after optional idle gaps); called at posedge+1
   task automatic drive(input int px, input bit sof);
      exp_t e;
      while (int'($urandom_range(99)) < gap_pct) begin
         in_valid = 1'b0;
         in_sof   = 1'($urandom_range(1));
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = 8'(px);
      if (sof) begin
         mr = 0;
         mc = 0;
      end
      img[mr][mc] = px;
      if (mr >= 2 && mc >= 2) begin
         e = model(mr, mc);
         e.cyc = cyc + 3;
         sbq.push_back(e);
      end
      if (mc == W-1) begin
         mc = 0;
         mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_pixels(input int kind, input bit first_sof, input int stop_r, input int stop_c);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            if (r == stop_r && c == stop_c) return;
            drive(pix(kind, r, c), first_sof && r == 0 && c == 0);
         end
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() > 0 && n < 30) begin
         @(posedge clk); n++;
      end
      repeat (4) @(posedge clk);
      #1;
      check("drain_empty", sbq.size(), 0);
   endtask

   task automatic tally_frame(input string nm, input int kind, input int en, input int emag, input int edir);
      drain();
      n_out = 0;
      mag_sum = 0;
      dir_sum = 0;
      send_pixels(kind, 1'b1, H, 0);
      drain();
      check({nm, "_count"}, n_out, en);
      check({nm, "_magsum"}, mag_sum, emag);
      check({nm, "_dirsum"}, dir_sum, edir);
   endtask

   task automatic check_reset_outs();
      check("rst_valid", int'(out_valid), 0);
      check("rst_mag", int'(out_mag), 0);
      check("rst_dir", int'(out_dir), 0);
      check("rst_sof", int'(out_sof), 0);
      check("rst_eof", int'(out_eof), 0);
   endtask

   // Monitor: every presented output must match the head of the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (out_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: mag %0d dir %0d with no pending expectation", out_mag, out_dir);
            end else begin
               e = sbq.pop_front();
               check("mag", int'(out_mag), e.mag);
               check("dir", int'(out_dir), e.dir);
               check("sof", int'(out_sof), e.sof);
               check("eof", int'(out_eof), e.eof);
               check("latency_cycle", cyc, e.cyc);
               n_out++;
               mag_sum += int'(out_mag);
               dir_sum += int'(out_dir);
            end
         end else if (out_sof || out_eof) begin
            check("flags_without_valid", int'({out_sof, out_eof}), 0);
         end
      end
   end

   initial begin
      #1 rst = 1'b0;
      #1 check_reset_outs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      gap_pct = 0;
      tally_frame("const50", 0, 24, 0, 0);
      tally_frame("vstep", 1, 24, 8 * 400, 0);
      tally_frame("hstep", 2, 24, 12 * 800, 24);
      tally_frame("ramp", 3, 24, 24 * 160, 24);
      tally_frame("antiramp", 4, 24, 24 * 160, 72);

      // Random data with gaps; second frame wraps without in_sof
      gap_pct = 35;
      send_pixels(5, 1'b1, H, 0);
      send_pixels(5, 1'b0, H, 0);
      drain();

      // Mid-frame restart at (3,5)
      send_pixels(5, 1'b1, 3, 5);
      send_pixels(5, 1'b1, H, 0);
      drain();

      // Reset mid-row with results in flight
      gap_pct = 0;
      send_pixels(5, 1'b1, 3, 4);
      rst = 1'b0;
      #1 check_reset_outs();
      sbq.delete();
      mr = 0;
      mc = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      gap_pct = 25;
      n_out = 0;
      send_pixels(5, 1'b1, H, 0);
      drain();
      check("post_reset_count", n_out, 24);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end
endmodule
